// File: rtl/word_block_serializer_if.sv
// Handshake bundle for the word block serializer:
// parallel block load in, addressed serial words out.
interface word_block_serializer_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] i_word0;
  logic [WORD_SIZE-1:0] i_word1;
  logic [WORD_SIZE-1:0] i_word2;
  logic [WORD_SIZE-1:0] i_word3;
  logic                 i_load;
  logic                 o_load_ready;
  logic [WORD_SIZE-1:0] o_word;
  logic [1:0]           o_address;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_last;
  logic                 o_block_done;

  modport master (
    output i_word0,
    output i_word1,
    output i_word2,
    output i_word3,
    output i_load,
    output i_ready,
    input  o_load_ready,
    input  o_word,
    input  o_address,
    input  o_valid,
    input  o_last,
    input  o_block_done
  );

  modport slave (
    input  i_word0,
    input  i_word1,
    input  i_word2,
    input  i_word3,
    input  i_load,
    input  i_ready,
    output o_load_ready,
    output o_word,
    output o_address,
    output o_valid,
    output o_last,
    output o_block_done
  );
endinterface

// File: rtl/word_block_serializer.sv
// Parallel 4-word block in, one addressed word per handshake out.
// Active + pending slots let back-to-back blocks stream without a gap.
module word_block_serializer #(
  parameter int WORD_SIZE = 16
) (
  input logic                   i_clk,
  input logic                   i_rst,
  word_block_serializer_if.slave bus
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  typedef logic [3:0][WORD_SIZE-1:0] blk_t;

  state_t     state;
  state_t     state_n;
  blk_t       act;
  blk_t       act_n;
  blk_t       pend;
  blk_t       pend_n;
  blk_t       blk_in;
  logic       pend_full;
  logic       pend_full_n;
  logic [1:0] idx;
  logic [1:0] idx_n;
  logic       hs;
  logic       load_acc;
  logic       last_hs;
  logic       stream_n;

  assign blk_in   = {bus.i_word3, bus.i_word2,
                     bus.i_word1, bus.i_word0};
  assign hs       = (state == STREAM) && bus.i_ready;
  assign load_acc = bus.i_load && !pend_full;
  assign last_hs  = hs && (idx == 2'd3);
  assign stream_n = (state_n == STREAM);

  always_comb begin
    state_n     = state;
    act_n       = act;
    pend_n      = pend;
    pend_full_n = pend_full;
    idx_n       = idx;
    unique case (state)
      IDLE: begin
        if (load_acc) begin
          act_n   = blk_in;
          idx_n   = 2'd0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        // a load on the final handshake bypasses pending
        if (load_acc && !last_hs) begin
          pend_n      = blk_in;
          pend_full_n = 1'b1;
        end
        if (hs) begin
          if (idx != 2'd3) begin
            idx_n = idx + 2'd1;
          end else if (pend_full) begin
            act_n       = pend;
            pend_full_n = 1'b0;
            idx_n       = 2'd0;
          end else if (load_acc) begin
            act_n = blk_in;
            idx_n = 2'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      act              <= '0;
      pend             <= '0;
      pend_full        <= 1'b0;
      idx              <= 2'd0;
      bus.o_valid      <= 1'b0;
      bus.o_word       <= '0;
      bus.o_address    <= 2'd0;
      bus.o_last       <= 1'b0;
      bus.o_block_done <= 1'b0;
      bus.o_load_ready <= 1'b1;
    end else begin
      state            <= state_n;
      act              <= act_n;
      pend             <= pend_n;
      pend_full        <= pend_full_n;
      idx              <= idx_n;
      bus.o_valid      <= stream_n;
      bus.o_word       <= stream_n ? act_n[idx_n] : '0;
      bus.o_address    <= stream_n ? idx_n : 2'd0;
      bus.o_last       <= stream_n && (idx_n == 2'd3);
      bus.o_block_done <= last_hs;
      bus.o_load_ready <= !pend_full_n;
    end
  end

endmodule
